wb_bram_arbiter: RTL
====================

Name: wb_bram_arbiter

Overview:
- Two-master Wishbone (pipelined) arbiter that shares one port of the dual-port Wishbone BRAM between requesters A and B.
- Round-robin grant, held for a whole bus cycle (CYC-locked). Tracks outstanding strobes so acks always route to the master that issued them.
- Sits between the two bus masters and one BRAM slave port.

Parameters:
- AW, 10, address width in words
- DW, 32, data width; SEL width is DW/8
- LGFLIGHT, 3, log2 of the maximum number of outstanding (accepted, unacked) strobes
- TIMEOUT, 64, watchdog cycles; used only with the optional feature

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_a_cyc, i_a_stb, i_a_we  in  1 each  master A cycle, strobe, write enable
- i_a_addr  in  AW  master A address
- i_a_data  in  DW  master A write data
- i_a_sel  in  DW/8  master A byte select
- o_a_stall, o_a_ack, o_a_err  out  1 each  master A stall, ack, error
- o_a_data  out  DW  master A read data
- i_b_*, o_b_*  same set as master A, for master B
- o_s_cyc, o_s_stb, o_s_we  out  1 each  slave (BRAM) cycle, strobe, write enable
- o_s_addr  out  AW  slave address
- o_s_data  out  DW  slave write data
- o_s_sel  out  DW/8  slave byte select
- i_s_stall, i_s_ack, i_s_err  in  1 each  slave stall, ack, error
- i_s_data  in  DW  slave read data
- o_grant  out  2  one-hot grant: [0]=A, [1]=B; 00 when none

Behaviour:
- Reset (async, i_reset_n=0):
  - state=IDLE, o_grant=00, outstanding count=0, round-robin pointer=A-preferred.
  - o_s_cyc=o_s_stb=0, all acks/errs=0, both stalls=1.
- States: IDLE, GNT_A, GNT_B, DRAIN.
- IDLE:
  - Only one of i_a_cyc / i_b_cyc high: grant that master.
  - Both high: grant the master not granted most recently.
  - Transition is registered. cyc seen at edge n gives grant visible after edge n; first strobe can be forwarded in the cycle after cyc rises (1-cycle arbitration latency).
- GNT_x:
  - o_s_cyc=i_x_cyc; o_s_stb=i_x_stb & i_x_cyc; we/addr/data/sel muxed from master x.
  - o_x_stall=i_s_stall, or forced 1 when count==2**LGFLIGHT-1.
  - o_x_ack=i_s_ack and o_x_err=i_s_err while i_x_cyc=1. o_x_data=i_s_data.
  - The non-granted master sees stall=1, ack=0, err=0.
- Outstanding count:
  - +1 on (o_s_stb & !i_s_stall & !forced stall); -1 on (i_s_ack | i_s_err).
  - Both in the same cycle: count unchanged. Count never wraps.
- Grant release, when the granted master drops cyc:
  - count==0 (after this edge's update): next state is the other master if its cyc is high, else IDLE. No idle cycle on hand-over.
  - count!=0: go to DRAIN with o_s_cyc=0. Acks/errs arriving in DRAIN are swallowed, not forwarded. Exit to IDLE when count reaches 0.
- The slave acks every accepted strobe exactly once, so DRAIN always terminates.
- i_s_err: forwarded like an ack; no state change.
- Reset mid-transfer: outputs return to reset values immediately. Pending acks are discarded.
- Round-robin pointer updates only when a grant is issued.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN
- Defined:
  - A counter runs while in GNT_x with o_s_stb & i_s_stall, or in DRAIN. It clears on any accepted strobe, ack, or state change.
  - At TIMEOUT cycles: pulse o_x_err for one cycle (GNT_x only), force count=0, go to IDLE.
  - The master must then drop cyc before it can be re-granted.
- Undefined: no watchdog; a slave that stalls forever holds the grant forever.

Test Plan:
- A only: A raises cyc and issues 4 reads at 0x010..0x013, BRAM returns 1-cycle acks -> o_grant=01 one cycle after cyc; 4 acks on A; B sees stall=1 throughout; count returns to 0.
- Contention: A and B raise cyc in the same cycle from reset -> A granted first. A drops cyc with count=0 -> o_grant=10 on the next edge with no IDLE cycle. Repeat the simultaneous request -> A then B again in alternation (rr pointer honoured).
- Drain: B issues 3 back-to-back writes, drops cyc the cycle after the third accept -> state=DRAIN, o_s_cyc=0, 3 acks swallowed (o_b_ack=0), then IDLE.
- Flight limit, LGFLIGHT=3: A pipelines 10 strobes with acks held off -> o_a_stall forced 1 after 7 accepted; released after the first ack.
- Async reset asserted mid-burst with count=2 -> o_s_cyc=0 and o_grant=00 the same cycle. After release, A's new request is granted normally.
- With WB_ARB_TIMEOUT_EN, TIMEOUT=64: slave holds stall=1 while A strobes -> o_a_err pulses at cycle 64, state=IDLE, count=0.

Source files
------------

// File: rtl/wb_bram_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bram_arbiter
//   Two-master pipelined Wishbone arbiter in front of one BRAM slave port.
//   Round-robin grant, locked for the whole bus cycle (CYC). Accepted but
//   unacknowledged strobes are counted so that acks always go back to the
//   master that issued them; when a master drops CYC with strobes still in
//   flight the arbiter drains them (swallowing their acks) before re-arbitrating.
//
//   Optional feature: define WB_ARB_TIMEOUT_EN to enable a watchdog that
//   aborts a cycle stuck behind a stalled/unresponsive slave after TIMEOUT
//   cycles (error pulse to the granted master, in-flight count cleared).
//
// Ports:
//   i_clk, i_reset_n        clock (rising edge), async active-low reset
//   i_a_* / o_a_*           master A Wishbone port (cyc/stb/we/addr/data/sel,
//                           stall/ack/err/data)
//   i_b_* / o_b_*           master B Wishbone port (same set)
//   o_s_* / i_s_*           slave (BRAM) Wishbone port
//   o_grant                 one-hot grant, [0]=A [1]=B, 00 when none
// -----------------------------------------------------------------------------
module wb_bram_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int LGFLIGHT = 3,
    parameter int TIMEOUT  = 64
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    // master A
    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_stall,
    output logic            o_a_ack,
    output logic            o_a_err,
    output logic [DW-1:0]   o_a_data,
    // master B
    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_stall,
    output logic            o_b_ack,
    output logic            o_b_err,
    output logic [DW-1:0]   o_b_data,
    // slave
    output logic            o_s_cyc,
    output logic            o_s_stb,
    output logic            o_s_we,
    output logic [AW-1:0]   o_s_addr,
    output logic [DW-1:0]   o_s_data,
    output logic [DW/8-1:0] o_s_sel,
    input  logic            i_s_stall,
    input  logic            i_s_ack,
    input  logic            i_s_err,
    input  logic [DW-1:0]   i_s_data,
    output logic [1:0]      o_grant
);

    typedef enum logic [1:0] {S_IDLE, S_GNT_A, S_GNT_B, S_DRAIN} state_t;

    localparam logic [LGFLIGHT-1:0] CNT_MAX = {LGFLIGHT{1'b1}};

    state_t              r_state, w_state_nxt;
    logic [LGFLIGHT-1:0] r_count, w_count_nxt;
    logic                r_pref_b;      // 1: B wins the next simultaneous request

    logic w_gnt_a, w_gnt_b, w_full, w_stb_req, w_accept, w_retire;
    logic w_req_a, w_req_b, w_fire;

    assign w_gnt_a = (r_state == S_GNT_A);
    assign w_gnt_b = (r_state == S_GNT_B);
    assign w_full  = (r_count == CNT_MAX);

    // Slave-side request mux.
    always_comb begin
        o_s_cyc   = 1'b0;
        w_stb_req = 1'b0;
        o_s_we    = i_a_we;
        o_s_addr  = i_a_addr;
        o_s_data  = i_a_data;
        o_s_sel   = i_a_sel;
        if (w_gnt_a) begin
            o_s_cyc   = i_a_cyc;
            w_stb_req = i_a_stb & i_a_cyc;
        end else if (w_gnt_b) begin
            o_s_cyc   = i_b_cyc;
            w_stb_req = i_b_stb & i_b_cyc;
            o_s_we    = i_b_we;
            o_s_addr  = i_b_addr;
            o_s_data  = i_b_data;
            o_s_sel   = i_b_sel;
        end
    end

    // The strobe is withheld from the slave while the flight window is full:
    // the master sees a forced stall, so a slave accepting it would lose track.
    assign o_s_stb  = w_stb_req & ~w_full;
    assign w_accept = o_s_stb & ~i_s_stall;
    assign w_retire = (i_s_ack | i_s_err) & (r_count != '0);

    // Watchdog
`ifdef WB_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] r_wdog;
    logic           r_hold_a, r_hold_b;   // timed-out master must drop CYC first
    logic           w_wd_run, w_wd_clr;

    assign w_wd_run = ((w_gnt_a | w_gnt_b) & o_s_stb & i_s_stall) | (r_state == S_DRAIN);
    assign w_wd_clr = ~w_wd_run | w_accept | i_s_ack | i_s_err | (w_state_nxt != r_state);
    assign w_fire   = w_wd_run & ~(w_accept | i_s_ack | i_s_err)
                    & (r_wdog == WDW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wdog   <= '0;
            r_hold_a <= 1'b0;
            r_hold_b <= 1'b0;
        end else begin
            if (w_fire || w_wd_clr)
                r_wdog <= '0;
            else
                r_wdog <= r_wdog + 1'b1;

            if (w_fire && w_gnt_a)  r_hold_a <= 1'b1;
            else if (!i_a_cyc)      r_hold_a <= 1'b0;

            if (w_fire && w_gnt_b)  r_hold_b <= 1'b1;
            else if (!i_b_cyc)      r_hold_b <= 1'b0;
        end
    end

    assign w_req_a = i_a_cyc & ~r_hold_a;
    assign w_req_b = i_b_cyc & ~r_hold_b;
`else
    assign w_fire  = 1'b0;
    assign w_req_a = i_a_cyc;
    assign w_req_b = i_b_cyc;
`endif

    // Master-side responses
    always_comb begin
        o_a_stall = 1'b1;
        o_a_ack   = 1'b0;
        o_a_err   = 1'b0;
        o_b_stall = 1'b1;
        o_b_ack   = 1'b0;
        o_b_err   = 1'b0;
        if (w_gnt_a) begin
            o_a_stall = i_s_stall | w_full;
            o_a_ack   = i_s_ack & i_a_cyc;
            o_a_err   = (i_s_err & i_a_cyc) | w_fire;
        end else if (w_gnt_b) begin
            o_b_stall = i_s_stall | w_full;
            o_b_ack   = i_s_ack & i_b_cyc;
            o_b_err   = (i_s_err & i_b_cyc) | w_fire;
        end
    end

    assign o_a_data = i_s_data;
    assign o_b_data = i_s_data;
    assign o_grant  = {w_gnt_b, w_gnt_a};

    // In-flight counter next value (a simultaneous accept and retire cancel).
    always_comb begin
        w_count_nxt = r_count;
        case ({w_accept, w_retire})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
        if (w_fire)
            w_count_nxt = '0;
    end

    // Next state. Release decisions use the post-update count so that a
    // last ack arriving together with the CYC drop allows a direct hand-over.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_a && w_req_b)
                    w_state_nxt = r_pref_b ? S_GNT_B : S_GNT_A;
                else if (w_req_a)
                    w_state_nxt = S_GNT_A;
                else if (w_req_b)
                    w_state_nxt = S_GNT_B;
            end
            S_GNT_A: begin
                if (!i_a_cyc) begin
                    if (w_count_nxt != '0) w_state_nxt = S_DRAIN;
                    else if (w_req_b)      w_state_nxt = S_GNT_B;
                    else                   w_state_nxt = S_IDLE;
                end
            end
            S_GNT_B: begin
                if (!i_b_cyc) begin
                    if (w_count_nxt != '0) w_state_nxt = S_DRAIN;
                    else if (w_req_a)      w_state_nxt = S_GNT_A;
                    else                   w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_count_nxt == '0)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_fire)
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_pref_b <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            // Pointer moves only on a fresh grant (including hand-over).
            if (w_state_nxt == S_GNT_A && r_state != S_GNT_A)
                r_pref_b <= 1'b1;
            else if (w_state_nxt == S_GNT_B && r_state != S_GNT_B)
                r_pref_b <= 1'b0;
        end
    end

endmodule
